// File: rtl/rival_car_controller_if.sv
// rival_car_controller_if: game-state inputs and rival car outputs between the car FSM, rival logic and display
interface rival_car_controller_if;
   logic       running;
   logic [9:0] player_x;
   logic [9:0] rival_x;
   logic [9:0] rival_y;
   logic       rival_visible;
   logic       rival_collision;
   logic [7:0] score;
   modport master (output running, player_x, input rival_x, rival_y, rival_visible, rival_collision, score);
   modport slave (input running, player_x, output rival_x, rival_y, rival_visible, rival_collision, score);
endinterface

// File: rtl/rival_car_controller.sv
// rival_car_controller: spawns a rival car in an LFSR-chosen lane, scrolls it down, flags overlap with the player and counts passes
module rival_car_controller #(
   parameter int CLK_FREQ_HZ    = 100000000,
   parameter int SCROLL_FREQ_HZ = 50,
   parameter int MAX_COUNT      = CLK_FREQ_HZ / SCROLL_FREQ_HZ - 1,
   parameter int ROAD_LEFT      = 245,
   parameter int LANE_PITCH     = 18,
   parameter int CAR_WIDTH      = 14,
   parameter int CAR_HEIGHT     = 16,
   parameter int PLAYER_Y       = 400,
   parameter int SCREEN_H       = 480,
   parameter int MOVE_STEP      = 2,
   parameter int GAP_TICKS      = 25,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic clk,
   input logic reset,
   rival_car_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SPAWN, DESCEND, GAP, HIT} state_t;
   state_t      state_q;
   logic [9:0]  x_q, y_q;
   logic        vis_q, col_q;
   logic [7:0]  score_q, lfsr_q;
   logic [23:0] div_q;
   logic [15:0] gap_q;
   logic        tick, overlap;
   logic [9:0]  spawn_x;
   logic [10:0] rx, ry, px;
   assign tick    = div_q == 24'(MAX_COUNT);
   assign spawn_x = 10'(ROAD_LEFT + 2) + 10'(lfsr_q[1:0]) * 10'(LANE_PITCH);
   assign rx = {1'b0, x_q};
   assign ry = {1'b0, y_q};
   assign px = {1'b0, bus.player_x};
   // 11-bit sums so the edge comparisons never wrap
   assign overlap = rx < px + 11'(CAR_WIDTH) && px < rx + 11'(CAR_WIDTH) &&
                    ry + 11'(CAR_HEIGHT) > 11'(PLAYER_Y) && ry < 11'(PLAYER_Y + CAR_HEIGHT);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         vis_q   <= 1'b0;
         col_q   <= 1'b0;
         score_q <= '0;
         lfsr_q  <= LFSR_SEED;
         div_q   <= '0;
         gap_q   <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + 24'd1;
         case (state_q)
            IDLE: if (bus.running) state_q <= SPAWN;
            SPAWN: begin
               x_q     <= spawn_x;
               y_q     <= '0;
               vis_q   <= 1'b1;
               lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
               state_q <= DESCEND;
            end
            // collision has priority over leaving the screen
            DESCEND: if (bus.running) begin
               if (overlap) begin
                  col_q   <= 1'b1;
                  state_q <= HIT;
               end else if (y_q >= 10'(SCREEN_H)) begin
                  vis_q   <= 1'b0;
                  score_q <= score_q == 8'hFF ? score_q : score_q + 8'd1;
                  gap_q   <= '0;
                  state_q <= GAP;
               end else if (tick) y_q <= y_q + 10'(MOVE_STEP);
            end
            GAP: if (bus.running && tick) begin
               gap_q <= gap_q + 16'd1;
               if (gap_q == 16'(GAP_TICKS - 1)) state_q <= SPAWN;
            end
            default: ;
         endcase
      end
   assign bus.rival_x         = x_q;
   assign bus.rival_y         = y_q;
   assign bus.rival_visible   = vis_q;
   assign bus.rival_collision = col_q;
   assign bus.score           = score_q;
endmodule

// File: tb/tb_rival_car_controller.sv
// tb_rival_car_controller: directed checks of spawn, scroll, gap, freeze, collision, reset and score saturation
module tb_rival_car_controller;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   rival_car_controller_if bus ();
   rival_car_controller #(.MAX_COUNT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] sig(input int which);
      return which == 0 ? 32'(bus.rival_y) : which == 1 ? 32'(bus.rival_visible) : 32'(bus.rival_collision);
   endfunction
   // waits on negedges until the selected output equals v, then compares (a timeout shows up as a failure)
   task automatic wait_sig(input string tag, input int which, input logic [31:0] v, input int budget, output int n);
      n = 0;
      while (sig(which) !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, sig(which), v);
   endtask
   initial begin
      reset = 1'b1;
      bus.running = 1'b0;
      bus.player_x = 10'd301;
      repeat (2) @(negedge clk);
      check("rst_x", 32'(bus.rival_x), 0);
      check("rst_y", 32'(bus.rival_y), 0);
      check("rst_vis", 32'(bus.rival_visible), 0);
      check("rst_col", 32'(bus.rival_collision), 0);
      check("rst_score", 32'(bus.score), 0);
      reset = 1'b0;
      bus.running = 1'b1;
      @(negedge clk);
      check("spawn_lat1", 32'(bus.rival_visible), 0);
      @(negedge clk);
      check("spawn_vis", 32'(bus.rival_visible), 1);
      check("spawn_x", 32'(bus.rival_x), 265);
      check("spawn_y", 32'(bus.rival_y), 0);
      check("spawn_score", 32'(bus.score), 0);
      check("spawn_col", 32'(bus.rival_collision), 0);
      wait_sig("step_y2", 0, 2, 10, cyc);
      repeat (4) @(negedge clk);
      check("step_y4", 32'(bus.rival_y), 4);
      wait_sig("pass_vis0", 1, 0, 1500, cyc);
      check("pass_score", 32'(bus.score), 1);
      check("pass_y", 32'(bus.rival_y), 480);
      check("pass_col", 32'(bus.rival_collision), 0);
      wait_sig("gap_vis1", 1, 1, 200, cyc);
      check("gap_cycles", 32'(cyc), 100);
      check("spawn2_x", 32'(bus.rival_x), 283);
      check("spawn2_y", 32'(bus.rival_y), 0);
      wait_sig("frz_y100", 0, 100, 500, cyc);
      bus.running = 1'b0;
      repeat (200) @(negedge clk);
      check("frz_hold_y", 32'(bus.rival_y), 100);
      check("frz_hold_vis", 32'(bus.rival_visible), 1);
      bus.running = 1'b1;
      wait_sig("frz_y102", 0, 102, 8, cyc);
      repeat (4) @(negedge clk);
      check("frz_y104", 32'(bus.rival_y), 104);
      wait_sig("mid_y200", 0, 200, 500, cyc);
      reset = 1'b1;
      #1;
      check("mid_x", 32'(bus.rival_x), 0);
      check("mid_y", 32'(bus.rival_y), 0);
      check("mid_vis", 32'(bus.rival_visible), 0);
      check("mid_score", 32'(bus.score), 0);
      @(negedge clk);
      bus.player_x = 10'd270;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_respawn_x", 32'(bus.rival_x), 265);
      wait_sig("col_y384", 0, 384, 2000, cyc);
      @(negedge clk);
      check("col_y384_none", 32'(bus.rival_collision), 0);
      wait_sig("col_y386", 0, 386, 8, cyc);
      check("col_lat0", 32'(bus.rival_collision), 0);
      @(negedge clk);
      check("col_lat1", 32'(bus.rival_collision), 1);
      repeat (40) @(negedge clk);
      check("col_sticky", 32'(bus.rival_collision), 1);
      check("col_frozen_y", 32'(bus.rival_y), 386);
      check("col_score", 32'(bus.score), 0);
      check("col_vis", 32'(bus.rival_visible), 1);
      reset = 1'b1;
      bus.player_x = 10'd301;
      @(negedge clk);
      check("col_rst", 32'(bus.rival_collision), 0);
      reset = 1'b0;
      wait_sig("sat_vis1", 1, 1, 10, cyc);
      force dut.score_q = 8'd255;
      @(negedge clk);
      release dut.score_q;
      @(negedge clk);
      check("sat_pre", 32'(bus.score), 255);
      wait_sig("sat_vis0", 1, 0, 1500, cyc);
      check("sat_score", 32'(bus.score), 255);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rival_car_controller.md
# rival_car_controller

Generates the rival car for the racing game: it spawns a car in one of four pseudo-random lanes, scrolls it down the road at a fixed rate, and detects bounding-box overlap with the player car. Sits directly upstream of the player car-control FSM. It consumes that FSM's `running` and `current_car_x` outputs and drives its `rival_collision` input. It also counts cars passed (score) for the display stage.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100000000: system clock frequency.
- `SCROLL_FREQ_HZ`, 50: rival scroll rate. `MAX_COUNT = CLK_FREQ_HZ/SCROLL_FREQ_HZ - 1`; test benches override it to a small value.
- `ROAD_LEFT`, 245: x of the left road edge.
- `LANE_PITCH`, 18: x spacing between lanes.
- `CAR_WIDTH`, 14: car width (player and rival).
- `CAR_HEIGHT`, 16: car height (player and rival).
- `PLAYER_Y`, 400: fixed top y of the player car.
- `SCREEN_H`, 480: y at which the rival has left the screen.
- `MOVE_STEP`, 2: y increment per scroll tick.
- `GAP_TICKS`, 25: scroll ticks between despawn and the next spawn.
- `LFSR_SEED`, 8'hA5: LFSR reset value.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high. The top level drives it from the restart button, together with the car-control FSM.
- `running`, in, 1: game active, from the car-control FSM.
- `player_x`, in, 10: player car left x (`current_car_x`).
- `rival_x`, out, 10: rival left x.
- `rival_y`, out, 10: rival top y.
- `rival_visible`, out, 1: rival on screen, draw it.
- `rival_collision`, out, 1: sticky collision flag.
- `score`, out, 8: cars passed, saturating.

## Operation
- States: IDLE, SPAWN, DESCEND, GAP, HIT.
- IDLE:
  - Entered on reset.
  - Moves to SPAWN on the first cycle with `running`=1.
- SPAWN (exactly one cycle):
  - Lane = `lfsr[1:0]`; `rival_x <= ROAD_LEFT + 2 + lane*LANE_PITCH`, giving x ∈ {247, 265, 283, 301}.
  - `rival_y <= 0`, `rival_visible <= 1`.
  - LFSR steps once.
  - Next state: DESCEND.
- LFSR:
  - 8-bit Fibonacci: shift left, bit0 = b7^b5^b4^b3.
  - Steps only in SPAWN, so the lane sequence is deterministic: A5→lane1, 4A→lane2, …
- DESCEND:
  - On each scroll tick with `running`=1: `rival_y <= rival_y + MOVE_STEP`.
  - When `rival_y >= SCREEN_H`: `rival_visible <= 0`, `score <= min(score+1, 255)`, next state GAP.
- GAP:
  - Counts GAP_TICKS scroll ticks while `running`=1, then moves to SPAWN.
  - The gap counter clears on entry to GAP.
- Overlap (combinational, evaluated only in DESCEND): all four must hold.
  - `rival_x < player_x + CAR_WIDTH`
  - `player_x < rival_x + CAR_WIDTH`
  - `rival_y + CAR_HEIGHT > PLAYER_Y`
  - `rival_y < PLAYER_Y + CAR_HEIGHT`
  - All sums are computed at 11 bits so nothing wraps.
- HIT:
  - Entered on overlap: `rival_collision <= 1`.
  - Position freezes, `rival_visible` stays 1.
  - Exits only by reset.
- Freeze: `running`=0 in DESCEND or GAP holds all state, the position and the gap counter. Ticks are ignored, not queued.
- Simultaneous events:
  - Overlap and off-screen in the same cycle: collision wins, score is unchanged.
  - A scroll tick while `running`=0: no motion.
- Scroll divider:
  - Free-running 24-bit counter, wraps at MAX_COUNT.
  - `tick` = (counter == MAX_COUNT).

## Timing
- Reset values (asynchronous):
  - state IDLE
  - `rival_x` = 0, `rival_y` = 0
  - `rival_visible` = 0, `rival_collision` = 0
  - `score` = 0
  - LFSR = LFSR_SEED
  - divider and gap counter = 0
- All outputs are registered.
- Overlap to `rival_collision`: 1 cycle. `rival_collision` is high on the clock edge after the overlapping `rival_y`/`player_x` are presented.
- `running` rise to `rival_visible`=1: 2 cycles (IDLE→SPAWN, SPAWN→DESCEND).
- Scroll update: `rival_y` changes on the clock edge on which `tick` is high.
- Reset mid-DESCEND: outputs clear asynchronously and state returns to IDLE. The next spawn uses lane 1 again.

## Test plan
- Reset and start: assert reset, then release it with `running`=1 → `rival_visible`=1, `rival_x`=265, `rival_y`=0 two cycles after release; `score`=0, `rival_collision`=0.
- Pass-through: `player_x`=301 (no overlap with lane 1), MAX_COUNT=3 → `rival_y` steps by 2 every 4 cycles. After 240 ticks `rival_visible`=0 and `score`=1. After 25 more ticks the second spawn has `rival_x`=283.
- Collision: `player_x`=270, lane 1 → at `rival_y`=386 the overlap is seen, `rival_collision`=1 one cycle later. It stays high, `rival_y` stays frozen at 386, and `score` stays 0.
- Freeze: drop `running` at `rival_y`=100 for 50 ticks → `rival_y` stays 100. On re-raise it advances 2 per tick.
- Score saturation: preload via 255 passes, or force `score`=255 → the next pass leaves `score`=255.
- Reset mid-descent: reset at `rival_y`=200 → all outputs 0 immediately. After release with `running`=1, the spawn is at x=265.
